// File: rtl/aer_out_fifo_tx_if.sv
// Sorter-side event stream and AER link signals of the buffered AER transmitter.
// Event stream: a transfer happens on every CLK edge where IN_VALID and IN_READY are both high;
// the source holds IN_ADDR stable while IN_VALID is high, and IN_READY never depends on IN_VALID.
interface aer_out_fifo_tx_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] IN_ADDR;
    logic              IN_VALID;
    logic              IN_READY;
    logic [ADDR_W-1:0] AERIN_ADDR;
    logic              AERIN_REQ;
    logic              AERIN_ACK;

    modport master (
        output IN_ADDR,
        output IN_VALID,
        input  IN_READY,
        input  AERIN_ADDR,
        input  AERIN_REQ,
        output AERIN_ACK
    );

    modport slave (
        input  IN_ADDR,
        input  IN_VALID,
        output IN_READY,
        output AERIN_ADDR,
        output AERIN_REQ,
        input  AERIN_ACK
    );
endinterface

// File: rtl/aer_out_fifo_tx.sv
// Buffered AER transmitter: event FIFO drained onto a 4-phase REQ/ACK link
// with a synchronised ACK, programmable address setup and an ACK timeout.
module aer_out_fifo_tx #(
    parameter int ADDR_W       = 10,
    parameter int FIFO_DEPTH   = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int SETUP_CYCLES = 1,
    parameter int ACK_TIMEOUT  = 1024,
    parameter int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    aer_out_fifo_tx_if.slave     bus,
    output logic                 BUSY,
    output logic [CNT_W-1:0]     FIFO_COUNT,
    output logic                 TIMEOUT_ERR,
    input  logic                 ERR_CLR,
    output logic [1:0]           DBG_STATE
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int SU_W  = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam int TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [SU_W-1:0] SU_LOAD = SU_W'((SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_REQ_HI, S_WAIT_ACK_LO} state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                push, pop;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                ack_s;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic                req_q, req_n;
    logic [SU_W-1:0]     su_cnt, su_cnt_n;
    logic [TO_W-1:0]     to_cnt, to_cnt_n;
    logic                to_hit;
    logic                err_q;

    assign bus.IN_READY = (count < CNT_W'(FIFO_DEPTH));
    assign push         = bus.IN_VALID & bus.IN_READY;

    // Count only moves on push xor pop; gating by IN_READY and !empty keeps it in range.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= bus.IN_ADDR;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) ack_sync <= '0;
        else     ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.AERIN_ACK};
    end
    assign ack_s = ack_sync[SYNC_STAGES-1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= S_IDLE;
            addr_q <= '0;
            req_q  <= 1'b0;
            su_cnt <= '0;
            to_cnt <= '0;
        end else begin
            state  <= state_n;
            addr_q <= addr_n;
            req_q  <= req_n;
            su_cnt <= su_cnt_n;
            to_cnt <= to_cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        addr_n   = addr_q;
        req_n    = req_q;
        su_cnt_n = su_cnt;
        to_cnt_n = to_cnt;
        pop      = 1'b0;
        to_hit   = 1'b0;
        case (state)
            S_IDLE: begin
                // A still-high ACK means the far side has not finished the last handshake.
                if (count != '0 && !ack_s) begin
                    pop    = 1'b1;
                    addr_n = mem[rd_ptr];
                    if (SETUP_CYCLES == 0) begin
                        req_n    = 1'b1;
                        to_cnt_n = '0;
                        state_n  = S_REQ_HI;
                    end else begin
                        su_cnt_n = SU_LOAD;
                        state_n  = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (su_cnt != '0) begin
                    su_cnt_n = su_cnt - SU_W'(1);
                end else if (!ack_s) begin
                    req_n    = 1'b1;
                    to_cnt_n = '0;
                    state_n  = S_REQ_HI;
                end
            end
            S_REQ_HI: begin
                if (ack_s) begin
                    req_n   = 1'b0;
                    state_n = S_WAIT_ACK_LO;
                end else if (ACK_TIMEOUT != 0 && to_cnt == TO_LAST) begin
                    req_n   = 1'b0;
                    to_hit  = 1'b1;
                    state_n = S_WAIT_ACK_LO;
                end else if (ACK_TIMEOUT != 0) begin
                    to_cnt_n = to_cnt + TO_W'(1);
                end
            end
            S_WAIT_ACK_LO: begin
                if (!ack_s) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // A timeout in the same cycle as ERR_CLR keeps the flag set.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)          err_q <= 1'b0;
        else if (to_hit)  err_q <= 1'b1;
        else if (ERR_CLR) err_q <= 1'b0;
    end

    assign bus.AERIN_ADDR = addr_q;
    assign bus.AERIN_REQ  = req_q;
    assign FIFO_COUNT     = count;
    assign TIMEOUT_ERR    = err_q;
    assign BUSY           = (state != S_IDLE) || (count != '0);
    assign DBG_STATE      = state;
endmodule

// File: tb/tb_aer_out_fifo_tx.sv
// Directed bench for aer_out_fifo_tx: link events are scoreboarded at every REQ rise,
// timing, flow control, timeout, stuck-ACK, wrap-around and mid-handshake reset are checked directly.
module tb_aer_out_fifo_tx;
    localparam int ADDR_W  = 10;
    localparam int DEPTH   = 8;
    localparam int SYNC    = 2;
    localparam int SETUP   = 1;
    localparam int TMO     = 16;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ACK_DLY = 3;

    logic             CLK;
    logic             RST;
    logic             busy;
    logic [CNT_W-1:0] fifo_count;
    logic             timeout_err;
    logic             err_clr;
    logic [1:0]       dbg_state;
    logic             ack_auto;
    logic             ack_force_val;
    logic             ack_resp;

    logic [ADDR_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    aer_out_fifo_tx_if #(.ADDR_W(ADDR_W)) bus ();

    assign bus.AERIN_ACK = ack_auto ? ack_resp : ack_force_val;

    aer_out_fifo_tx #(
        .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC),
        .SETUP_CYCLES(SETUP), .ACK_TIMEOUT(TMO), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .RST(RST), .bus(bus), .BUSY(busy), .FIFO_COUNT(fifo_count),
        .TIMEOUT_ERR(timeout_err), .ERR_CLR(err_clr), .DBG_STATE(dbg_state)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required $finish earlier");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    function automatic logic sig_of(input int which);
        case (which)
            0:       return bus.AERIN_REQ;
            1:       return bus.AERIN_ACK;
            default: return busy;
        endcase
    endfunction

    task automatic wait_sig(input string name, input int which, input logic val,
                            input int bound, output int n);
        n = 0;
        while (sig_of(which) !== val && n < bound) begin
            tick();
            n++;
        end
        check(name, sig_of(which), val);
    endtask

    // driver: holds the event until accepted, then records it as expected on the link
    task automatic push_ev(input logic [ADDR_W-1:0] a);
        int n;
        n = 0;
        bus.IN_ADDR  = a;
        bus.IN_VALID = 1'b1;
        while (!bus.IN_READY && n < 1000) begin
            tick();
            n++;
        end
        check("push_ready", bus.IN_READY, 1'b1);
        exp_q.push_back(a);
        tick();
        bus.IN_VALID = 1'b0;
    endtask

    // ACK responder: raises ACK ACK_DLY edges after seeing REQ, drops it likewise
    initial begin
        ack_resp = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (ack_auto && bus.AERIN_REQ && !ack_resp) begin
                repeat (ACK_DLY - 1) begin @(posedge CLK); #1; end
                ack_resp = 1'b1;
            end else if (ack_resp && !bus.AERIN_REQ) begin
                repeat (ACK_DLY - 1) begin @(posedge CLK); #1; end
                ack_resp = 1'b0;
            end
        end
    end

    // monitor: every REQ rise must carry the oldest expected event; ADDR frozen while REQ high
    initial begin
        logic              prev_req;
        logic [ADDR_W-1:0] prev_addr;
        logic [ADDR_W-1:0] e;
        prev_req  = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge CLK);
            if (bus.AERIN_REQ && !prev_req) begin
                if (exp_q.size() == 0) begin
                    check("link_extra_event", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("link_addr", bus.AERIN_ADDR, e);
                end
            end
            if (bus.AERIN_REQ && prev_req) check("addr_stable", bus.AERIN_ADDR, prev_addr);
            prev_req  = bus.AERIN_REQ;
            prev_addr = bus.AERIN_ADDR;
        end
    end

    initial begin
        int n;
        RST           = 1'b1;
        err_clr       = 1'b0;
        ack_auto      = 1'b0;
        ack_force_val = 1'b0;
        bus.IN_ADDR   = '0;
        bus.IN_VALID  = 1'b0;
        repeat (3) tick();
        RST = 1'b0;
        tick();

        // reset state
        check("rst_addr", bus.AERIN_ADDR, 0);
        check("rst_req", bus.AERIN_REQ, 0);
        check("rst_err", timeout_err, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", bus.IN_READY, 1);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 0);

        // single event, exact link timing
        ack_auto = 1'b1;
        bus.IN_ADDR  = 10'h155;
        bus.IN_VALID = 1'b1;
        exp_q.push_back(10'h155);
        tick();
        bus.IN_VALID = 1'b0;
        check("t1_count_after_push", fifo_count, 1);
        tick();
        check("t1_addr_k1", bus.AERIN_ADDR, 10'h155);
        check("t1_req_k1", bus.AERIN_REQ, 0);
        tick();
        check("t1_req_k2", bus.AERIN_REQ, 1);
        wait_sig("t1_ack_rise", 1, 1'b1, 50, n);
        wait_sig("t1_req_fall", 0, 1'b0, 50, n);
        check("t1_req_fall_delay", n, SYNC + 1);
        wait_sig("t1_ack_fall", 1, 1'b0, 50, n);
        check("t1_busy_ack_fall", busy, 1);
        repeat (SYNC + 1) tick();
        check("t1_busy_done", busy, 0);

        // burst of 10 with ACK held low: backpressure and ordering
        ack_auto = 1'b0;
        ack_force_val = 1'b0;
        for (int i = 1; i <= 9; i++) push_ev(ADDR_W'(i));
        check("t2_count_full", fifo_count, DEPTH);
        check("t2_ready_full", bus.IN_READY, 0);
        push_ev(10'h00A);
        check("t2_err_first_timeout", timeout_err, 1);
        ack_auto = 1'b1;
        wait_sig("t2_drain", 2, 1'b0, 2000, n);
        check("t2_no_loss", exp_q.size(), 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t2_err_cleared", timeout_err, 0);

        // ACK never comes: timeout after TMO cycles, then recovery
        ack_auto = 1'b0;
        push_ev(10'h3FF);
        wait_sig("t3_req_rise", 0, 1'b1, 50, n);
        wait_sig("t3_req_timeout", 0, 1'b0, 100, n);
        check("t3_req_high_cycles", n, TMO);
        check("t3_err_set", timeout_err, 1);
        tick();
        check("t3_state_idle", dbg_state, 0);
        check("t3_busy_idle", busy, 0);
        ack_auto = 1'b1;
        push_ev(10'h2AA);
        wait_sig("t3_next_sent", 2, 1'b0, 200, n);
        check("t3_err_sticky", timeout_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3_err_clr", timeout_err, 0);

        // ACK stuck high blocks the next request
        ack_auto = 1'b0;
        ack_force_val = 1'b1;
        repeat (4) tick();
        push_ev(10'h0C3);
        push_ev(10'h13C);
        repeat (10) tick();
        check("t4_req_blocked", bus.AERIN_REQ, 0);
        check("t4_count_held", fifo_count, 2);
        check("t4_state_idle", dbg_state, 0);
        ack_auto = 1'b1;
        wait_sig("t4_drain", 2, 1'b0, 300, n);

        // simultaneous push and pop at count 4
        ack_auto = 1'b0;
        ack_force_val = 1'b1;
        repeat (4) tick();
        push_ev(10'h011);
        push_ev(10'h022);
        push_ev(10'h033);
        push_ev(10'h044);
        check("t5_count4", fifo_count, 4);
        ack_force_val = 1'b0;
        repeat (SYNC) tick();
        bus.IN_ADDR  = 10'h055;
        bus.IN_VALID = 1'b1;
        exp_q.push_back(10'h055);
        tick();
        bus.IN_VALID = 1'b0;
        check("t5_count_pushpop", fifo_count, 4);
        check("t5_popped_head", bus.AERIN_ADDR, 10'h011);
        ack_auto = 1'b1;
        wait_sig("t5_drain", 2, 1'b0, 500, n);

        // 20 events: pointers wrap
        for (int i = 0; i < 20; i++) push_ev(ADDR_W'(i * 37 + 5));
        wait_sig("t5_wrap_drain", 2, 1'b0, 2000, n);
        check("t5_wrap_no_loss", exp_q.size(), 0);

        // reset mid-handshake with 5 queued
        ack_auto = 1'b0;
        ack_force_val = 1'b0;
        for (int i = 1; i <= 6; i++) push_ev(ADDR_W'(10'h100 + i));
        check("t6_req_high", bus.AERIN_REQ, 1);
        check("t6_count5", fifo_count, 5);
        #1;
        RST = 1'b1;
        #1;
        check("t6_req_async_low", bus.AERIN_REQ, 0);
        check("t6_count_async_zero", fifo_count, 0);
        tick();
        tick();
        exp_q.delete();
        RST = 1'b0;
        ack_auto = 1'b1;
        repeat (20) tick();
        check("t6_no_req_after", bus.AERIN_REQ, 0);
        check("t6_count_after", fifo_count, 0);
        check("t6_busy_after", busy, 0);
        check("end_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/aer_out_fifo_tx.md
Name: aer_out_fifo_tx

Overview:
Buffered, parametrised AER link transmitter. It accepts event addresses from the sorter over a valid/ready interface and stores them in an internal FIFO. It then drains them onto an asynchronous 4-phase REQ/ACK AER link, with a configurable ACK synchroniser depth, address-to-REQ setup time and ACK timeout. It sits between the sorter and the off-chip or neuron-core AER input.

Parameters:
ADDR_W, 10, AER address width (IMAGE_SIZE_BITS+2 for a 256-pixel image)
FIFO_DEPTH, 8, event FIFO entries; power of 2, >= 2
SYNC_STAGES, 2, flip-flops in the ACK synchroniser, >= 2
SETUP_CYCLES, 1, cycles AERIN_ADDR is held stable before AERIN_REQ rises; 0 allowed
ACK_TIMEOUT, 1024, max cycles in REQ_HI waiting for ACK; 0 disables the timeout
CNT_W, $clog2(FIFO_DEPTH+1), width of FIFO_COUNT

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
IN_ADDR  in  ADDR_W  event address from sorter
IN_VALID  in  1  IN_ADDR valid
IN_READY  out  1  FIFO can accept; push occurs when IN_VALID & IN_READY
AERIN_ADDR  out  ADDR_W  AER address, registered
AERIN_REQ  out  1  AER request, registered
AERIN_ACK  in  1  AER acknowledge, asynchronous to CLK
BUSY  out  1  state != IDLE or FIFO not empty
FIFO_COUNT  out  CNT_W  current FIFO occupancy
TIMEOUT_ERR  out  1  sticky ACK-timeout flag
ERR_CLR  in  1  synchronous clear for TIMEOUT_ERR

Behaviour:
- Reset: AERIN_ADDR=0, AERIN_REQ=0, TIMEOUT_ERR=0, FIFO empty (FIFO_COUNT=0), synchroniser flops=0, state=IDLE. IN_READY=1 and BUSY=0 while out of reset.
- Reset asserted mid-handshake: REQ drops immediately (async), all queued events are discarded.
- ack_s is AERIN_ACK after SYNC_STAGES CLK edges. All FSM decisions use ack_s only.
- IN_READY = (FIFO_COUNT < FIFO_DEPTH), derived from registered count only, with no combinational path from any input.
- Push and pop in the same cycle: count unchanged, data order preserved (FIFO, first-in first-out). A push while full cannot occur because IN_READY=0.
- FSM states are IDLE, SETUP, REQ_HI, WAIT_ACK_LO.
  - IDLE: when FIFO is not empty and ack_s==0: pop the head into AERIN_ADDR. If SETUP_CYCLES=0, set REQ=1 and go to REQ_HI; otherwise load the setup counter and go to SETUP. If ack_s==1, stay in IDLE (the previous handshake is not finished).
  - SETUP: count down SETUP_CYCLES cycles, then set REQ=1 and go to REQ_HI. ADDR is held.
  - REQ_HI: on ack_s==1, set REQ=0 and go to WAIT_ACK_LO. If ACK_TIMEOUT!=0 and the wait counter reaches ACK_TIMEOUT with ack_s still 0, set REQ=0, set TIMEOUT_ERR=1, drop the event and go to WAIT_ACK_LO. ACK arriving on the timeout cycle counts as a normal ACK, with no error.
  - WAIT_ACK_LO: on ack_s==0, go to IDLE. AERIN_ADDR holds its last value until the next pop.
- Latency, empty FIFO: push at edge k, pop and ADDR update at edge k+1, REQ rises at edge k+1+SETUP_CYCLES.
- Minimum per-event period is SETUP_CYCLES + 2*SYNC_STAGES + 3 cycles, plus the external ACK delay.
- ADDR never changes while REQ=1. REQ never rises while ack_s=1.
- ERR_CLR and a timeout in the same cycle: set wins.
- FIFO pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. The count saturates at neither end; it is kept consistent by the ready/empty gating.

Test Plan:
- Reset, then push a single 0x155 with an ACK responder of 3 cycles: ADDR=0x155 one cycle after push, REQ rises 1 cycle later (SETUP_CYCLES=1), REQ falls SYNC_STAGES+1 cycles after ACK rises, BUSY=0 after ACK falls.
- Hold ACK low and burst 10 pushes (0x001..0x00A) with FIFO_DEPTH=8: IN_READY=0 once count hits 8, the accepted events reach the link in exact order, and there are no losses.
- Push 0x3FF with ACK tied low and ACK_TIMEOUT=16: REQ falls 16 cycles after rising, TIMEOUT_ERR=1, FSM returns to IDLE, next event is sent. Pulse ERR_CLR: TIMEOUT_ERR=0.
- ACK stuck high from a previous transaction, FIFO non-empty: REQ stays 0 until ACK falls, then the next event is sent.
- Push and pop in the same cycle at count=4: count stays 4. Wrap-around after 20 events: data intact.
- Assert RST while REQ=1 with 5 events queued: REQ=0 asynchronously, FIFO_COUNT=0, and there is no REQ after reset release.
